// File: rtl/if_id_skid_stage_if.sv
// Valid/ready bus carrying a {PC+4, instruction} pair between pipeline stages.
// The master drives the payload; the slave returns ready.
interface if_id_skid_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               valid;
  logic               ready;
  logic [PC_W-1:0]    pcplusfour;
  logic [INSTR_W-1:0] instr;

  modport master (output valid, output pcplusfour, output instr, input ready);
  modport slave  (input valid, input pcplusfour, input instr, output ready);
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with valid/ready handshake, 2-entry skid buffer,
// bubble-injecting flush and a selectable capture edge.
//
// state    | meaning
// ST_EMPTY | nothing held, decode sees NOP, in_ready=1
// ST_ONE   | head valid, skid empty, in_ready=1
// ST_FULL  | head and skid valid, in_ready=0
module if_id_skid_stage #(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013),
  parameter bit                 NEG_EDGE  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  if_id_skid_stage_if.slave       in_if,
  if_id_skid_stage_if.master      out_if,
  input  logic                    flush_i,
  output logic [1:0]              occupancy_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    state_e             state;
    logic               in_ready;
    logic [PC_W-1:0]    main_pc;
    logic [INSTR_W-1:0] main_instr;
    logic [PC_W-1:0]    skid_pc;
    logic [INSTR_W-1:0] skid_instr;
  } regs_t;

  localparam regs_t REGS_RST = '{
    state:      ST_EMPTY,
    in_ready:   1'b1,
    main_pc:    '0,
    main_instr: '0,
    skid_pc:    '0,
    skid_instr: '0
  };

  regs_t regs_q, regs_d;
  logic  out_valid;
  logic  accept;
  logic  pop;

  assign accept = in_if.valid & regs_q.in_ready;
  assign pop    = out_valid & out_if.ready;

  // Both edge flavours share one next-state function; only the clock edge differs.
  if (NEG_EDGE) begin : g_negedge
    always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= REGS_RST;
      else        regs_q <= regs_d;
    end
  end else begin : g_posedge
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) regs_q <= REGS_RST;
      else        regs_q <= regs_d;
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (flush_i) begin
      regs_d.state = ST_EMPTY;
    end else begin
      case (regs_q.state)
        ST_EMPTY: begin
          if (accept) begin
            regs_d.state      = ST_ONE;
            regs_d.main_pc    = in_if.pcplusfour;
            regs_d.main_instr = in_if.instr;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            regs_d.main_pc    = in_if.pcplusfour;
            regs_d.main_instr = in_if.instr;
          end else if (accept) begin
            regs_d.state      = ST_FULL;
            regs_d.skid_pc    = in_if.pcplusfour;
            regs_d.skid_instr = in_if.instr;
          end else if (pop) begin
            regs_d.state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            regs_d.state      = ST_ONE;
            regs_d.main_pc    = regs_q.skid_pc;
            regs_d.main_instr = regs_q.skid_instr;
          end
        end
        default: regs_d.state = ST_EMPTY;
      endcase
    end
    // Registered ready: a function of the next state only, never of out_ready.
    regs_d.in_ready = (regs_d.state != ST_FULL);
  end

  always_comb begin
    out_valid         = (regs_q.state != ST_EMPTY);
    out_if.valid      = out_valid;
    out_if.pcplusfour = regs_q.main_pc;
    out_if.instr      = out_valid ? regs_q.main_instr : NOP_INSTR;
    in_if.ready       = regs_q.in_ready;
    occupancy_o       = regs_q.state;
  end

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: one falling-edge and one rising-edge
// instance, checked against a queue of expected entries.
module tb_if_id_skid_stage;
  localparam logic [31:0] NOP = 32'h00000013;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       n_flush, p_flush;
  logic [1:0] n_occ, p_occ;

  always #5 clk = ~clk;

  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32)) n_in ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32)) n_out ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32)) p_in ();
  if_id_skid_stage_if #(.PC_W(32), .INSTR_W(32)) p_out ();

  if_id_skid_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .NEG_EDGE(1'b1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_if(n_in), .out_if(n_out),
    .flush_i(n_flush), .occupancy_o(n_occ)
  );

  if_id_skid_stage #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP), .NEG_EDGE(1'b0)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_if(p_in), .out_if(p_out),
    .flush_i(p_flush), .occupancy_o(p_occ)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] last_pc = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called 1 time unit after the selected DUT's active edge; returns at the same phase one cycle later.
  task automatic cycle(input bit pe, input bit v, input logic [31:0] pc, input logic [31:0] ins,
                       input bit ordy, input bit fl);
    int          occ_m;
    bit          acc, pop;
    logic [31:0] occ, rdy, vld, opc, oins;
    if (pe) begin
      p_in.valid = v; p_in.pcplusfour = pc; p_in.instr = ins; p_out.ready = ordy; p_flush = fl;
    end else begin
      n_in.valid = v; n_in.pcplusfour = pc; n_in.instr = ins; n_out.ready = ordy; n_flush = fl;
    end
    occ_m = exp_q.size();
    occ   = pe ? 32'(p_occ) : 32'(n_occ);
    rdy   = pe ? 32'(p_in.ready) : 32'(n_in.ready);
    vld   = pe ? 32'(p_out.valid) : 32'(n_out.valid);
    opc   = pe ? p_out.pcplusfour : n_out.pcplusfour;
    oins  = pe ? p_out.instr : n_out.instr;
    check_val("occupancy", occ, 32'(occ_m));
    check_val("in_ready", rdy, 32'(occ_m < 2));
    check_val("out_valid", vld, 32'(occ_m != 0));
    if (occ_m == 0) begin
      check_val("nop_instr", oins, NOP);
      check_val("hold_pc", opc, last_pc);
    end else begin
      check_val("head_pc", opc, exp_q[0][63:32]);
      check_val("head_instr", oins, exp_q[0][31:0]);
      last_pc = exp_q[0][63:32];
    end
    acc = v && (occ_m < 2);
    pop = ordy && (occ_m != 0);
    if (pop) void'(exp_q.pop_front());
    if (fl) exp_q.delete();
    else if (acc) exp_q.push_back({pc, ins});
    #5;
    occ = pe ? 32'(p_occ) : 32'(n_occ);
    check_val("mid_cycle_occ", occ, 32'(occ_m));
    if (pe) @(posedge clk);
    else    @(negedge clk);
    #1;
  endtask

  initial begin
    n_in.valid = 0; n_in.pcplusfour = '0; n_in.instr = '0; n_out.ready = 0; n_flush = 0;
    p_in.valid = 0; p_in.pcplusfour = '0; p_in.instr = '0; p_out.ready = 0; p_flush = 0;
    #12 rst_n = 1'b1;
    @(negedge clk); #1;

    // streaming with decode always ready
    cycle(0, 1, 32'h04, 32'h00500093, 1, 0);
    cycle(0, 1, 32'h08, 32'h00A00113, 1, 0);
    cycle(0, 1, 32'h0C, 32'h002081B3, 1, 0);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);

    // stall into the skid buffer, offer a third entry while full, then drain
    cycle(0, 1, 32'h04, 32'h00500093, 0, 0);
    cycle(0, 1, 32'h08, 32'h00A00113, 0, 0);
    cycle(0, 1, 32'h0C, 32'h002081B3, 1, 0);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);

    // flush while full with a coinciding input, then flush held for several cycles
    cycle(0, 1, 32'h04, 32'h00500093, 0, 0);
    cycle(0, 1, 32'h08, 32'h00A00113, 0, 0);
    cycle(0, 1, 32'h10, 32'h00100073, 0, 1);
    cycle(0, 1, 32'h14, 32'h00000033, 0, 1);
    cycle(0, 1, 32'h18, 32'h00000033, 1, 1);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);

    // accept and pop on the same edge while holding one entry
    cycle(0, 1, 32'h20, 32'h00300193, 0, 0);
    cycle(0, 1, 32'h24, 32'h00400213, 1, 0);
    cycle(0, 1, 32'h28, 32'h00500293, 1, 1);
    cycle(0, 0, 32'h0,  32'h0,        1, 0);

    // asynchronous reset mid-cycle while full
    cycle(0, 1, 32'h30, 32'h00600313, 0, 0);
    cycle(0, 1, 32'h34, 32'h00700393, 0, 0);
    n_in.valid = 0; n_out.ready = 0;
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", 32'(n_out.valid), 32'd0);
    check_val("rst_out_instr", n_out.instr, NOP);
    check_val("rst_in_ready", 32'(n_in.ready), 32'd1);
    check_val("rst_occupancy", 32'(n_occ), 32'd0);
    check_val("rst_out_pc", n_out.pcplusfour, 32'd0);
    exp_q.delete();
    last_pc = '0;
    #2 rst_n = 1'b1;
    @(negedge clk); #1;
    cycle(0, 0, 32'h0, 32'h0, 0, 0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      cycle(0, bit'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
            bit'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0);

    // rising-edge instance: same streaming sequence
    n_out.ready = 0;
    exp_q.delete();
    last_pc = '0;
    @(posedge clk); #1;
    cycle(1, 1, 32'h04, 32'h00500093, 1, 0);
    cycle(1, 1, 32'h08, 32'h00A00113, 1, 0);
    cycle(1, 1, 32'h0C, 32'h002081B3, 1, 0);
    cycle(1, 0, 32'h0,  32'h0,        1, 0);
    cycle(1, 0, 32'h0,  32'h0,        1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage; replaces the plain stall-gated IF/ID latch.
- Adds a valid/ready handshake, a 2-entry skid buffer, a flush that injects a bubble, and a selectable capture edge.
- Sits between the fetch unit (PC+4, instruction) and decode; decode sees a NOP whenever the stage holds no valid entry.

Parameters:
- PC_W, 32, width of the PC+4 field.
- INSTR_W, 32, width of the instruction field.
- NOP_INSTR, 32'h00000013 (addi x0,x0,0), instruction presented when the stage is empty or flushed; width INSTR_W.
- NEG_EDGE, 1, 1 = all state updates on the falling edge of clk; 0 = rising edge.

Ports:
- clk  in  1  stage clock; active edge selected by NEG_EDGE.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents a valid PC+4/instruction pair.
- in_pcplusfour  in  PC_W  fetched PC+4.
- in_instr  in  INSTR_W  fetched instruction.
- in_ready  out  1  stage can accept this cycle; registered.
- flush  in  1  discard all held and incoming entries (branch/jump redirect).
- out_valid  out  1  out_pcplusfour/out_instr hold a valid entry.
- out_pcplusfour  out  PC_W  PC+4 of the head entry.
- out_instr  out  INSTR_W  head instruction; NOP_INSTR when out_valid=0.
- out_ready  in  1  decode consumes the head entry this cycle (0 = stall).
- occupancy  out  2  number of held entries, 0..2.

Behaviour:
- Single clock. rst_n is asynchronous and active-low: assertion immediately clears state regardless of clk; deassertion is sampled on the active edge.
- Reset values: out_valid=0, out_pcplusfour=0, out_instr=NOP_INSTR, in_ready=1, occupancy=0, skid register contents=0.
- Storage: head register (main) and skid register, each holding {pcplusfour, instr} plus a valid bit.
- Events:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Both are evaluated on the same active edge.
- States, encoded as occupancy:
  - EMPTY(0):
    - accept -> ONE, main<=in.
    - else stay.
    - pop is impossible.
  - ONE(1):
    - accept & pop -> ONE, main<=in.
    - accept & !pop -> FULL, skid<=in.
    - !accept & pop -> EMPTY.
    - else hold.
  - FULL(2):
    - in_ready=0, so accept is impossible.
    - pop -> ONE, main<=skid.
    - else hold.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. It updates on the same edge as the state and has no combinational path from out_ready.
- Latency: an entry accepted on edge N is visible on outputs after edge N with out_valid=1. Throughput is 1 entry/cycle while out_ready=1.
- Order is strictly FIFO; no entry is duplicated or dropped except by flush.
- out_instr = out_valid ? main.instr : NOP_INSTR (combinational output mux). out_pcplusfour holds its last value when empty, except after reset (0).
- flush:
  - Highest priority after reset. The next active edge goes to EMPTY, clears both valid bits, and sets in_ready=1.
  - An accept coinciding with flush is discarded.
  - A pop coinciding with flush completes (decode already consumed it).
- flush held for several cycles: the stage stays EMPTY; in_ready=1, but all inputs are discarded.
- Reset during FULL or mid-flush: immediate return to reset values; the skid contents are lost.
- With NEG_EDGE=1, fetch and decode (posedge logic) get a half-cycle setup window, matching the existing pipeline timing.

Test Plan:
- Reset:
  - Stimulus: assert rst_n=0 asynchronously mid-cycle with occupancy=2.
  - Required: out_valid=0, out_instr=32'h00000013, in_ready=1, occupancy=0 before the next edge.
- Streaming:
  - Stimulus: out_ready=1; feed pcplusfour 0x04,0x08,0x0C with instrs 0x00500093,0x00A00113,0x002081B3 on consecutive edges.
  - Required: each appears one edge later in order; occupancy stays 1; in_ready stays 1.
- Stall/skid:
  - Stimulus: out_ready=0 while accepting 0x04/0x00500093 then 0x08/0x00A00113.
  - Required: occupancy=2, in_ready=0, head=0x04.
  - Stimulus: then raise out_ready.
  - Required: head becomes 0x08 after one edge, then EMPTY after the next; a third entry offered while in_ready=0 is not taken.
- Flush:
  - Stimulus: at occupancy=2, assert flush together with in_valid=1 (0x10/0x00100073).
  - Required: after the edge, occupancy=0, out_valid=0, out_instr=NOP; 0x10 is never output.
- Simultaneous:
  - Stimulus: in ONE, accept and pop on the same edge.
  - Required: occupancy stays 1; new entry at head; old entry popped exactly once.
- Edge mode:
  - Stimulus: rerun the streaming test with NEG_EDGE=0.
  - Required: identical sequence, with updates on posedge only.
